// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared types and helpers for the load/store unit.
//  Revision    : 1.0
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        SPLIT  = 2'd2,
        RESP   = 2'd3
    } lsu_state_t;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

    // Number of bytes touched by an access of the given size.
    function automatic logic [2:0] byte_count(input logic size);
        return (size == SIZE_WORD) ? 3'd4 : 3'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_req_if / lsu_mem_if
//  Description : Core request/response bundle and data-memory port bundle.
//  Revision    : 1.0
// ============================================================================
interface lsu_req_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic              req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [31:0]       resp_rdata;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_err, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_err, resp_rdata
    );
endinterface

interface lsu_mem_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_size;
    logic              mem_rd;
    logic              mem_wr;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_addr, mem_wdata, mem_size, mem_rd, mem_wr,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_size, mem_rd, mem_wr,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/lsu_load_fmt.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_load_fmt
//  Description : Load data formatter: byte extension or word pass-through.
//  Revision    : 1.0
// ============================================================================
module lsu_load_fmt
    import lsu_pkg::*;
(
    input  wire logic        i_size,
    input  wire logic        i_unsigned,
    input  wire logic [31:0] i_raw,
    output logic      [31:0] o_data
);

    always_comb begin
        o_data = i_raw;
        if (i_size == SIZE_BYTE) begin
            o_data = i_unsigned ? {24'b0, i_raw[7:0]}
                                : {{24{i_raw[7]}}, i_raw[7:0]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Data-memory initiator; one load/store at a time, byte/word,
//                misaligned words split into four byte beats, range-checked.
//  Revision    : 1.0
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 32
) (
    input wire logic  clk,
    input wire logic  rst,
    lsu_req_if.slave  req,
    lsu_mem_if.master mem
);

    localparam logic [ADDR_W:0] c_last_addr = (ADDR_W+1)'(MEM_BYTES - 1);

    lsu_state_t        r_state;
    lsu_state_t        w_state_nxt;

    // Latched request
    logic              r_we;
    logic              r_size;
    logic              r_unsigned;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;

    // Split-access bookkeeping: beat index and bytes 0..2 of a split load
    logic [1:0]        r_beat;
    logic [1:0]        w_beat_nxt;
    logic [1:0]        w_beat_inc;
    logic [23:0]       r_asm;
    logic [23:0]       w_asm_nxt;

    // Registered outputs and their next values
    logic              r_resp_valid, w_resp_valid_nxt;
    logic              r_resp_err,   w_resp_err_nxt;
    logic [31:0]       r_resp_rdata, w_resp_rdata_nxt;
    logic [ADDR_W-1:0] r_mem_addr,   w_mem_addr_nxt;
    logic [31:0]       r_mem_wdata,  w_mem_wdata_nxt;
    logic              r_mem_size,   w_mem_size_nxt;
    logic              r_mem_rd,     w_mem_rd_nxt;
    logic              r_mem_wr,     w_mem_wr_nxt;

    logic [ADDR_W:0]   w_end_addr;
    logic              w_range_err;
    logic              w_misaligned;
    logic              w_accept;
    logic [7:0]        w_split_byte;
    logic              w_fmt_size;
    logic [31:0]       w_fmt_raw;
    logic [31:0]       w_fmt_data;

    // End address is one bit wider than the address so it cannot wrap.
    assign w_end_addr   = {1'b0, req.req_addr}
                        + (ADDR_W+1)'(byte_count(req.req_size))
                        - (ADDR_W+1)'(1);
    assign w_range_err  = (w_end_addr > c_last_addr);
    assign w_misaligned = (req.req_size == SIZE_WORD) && (req.req_addr[1:0] != 2'b00);
    assign w_accept     = req.req_valid && (r_state == IDLE);

    assign w_beat_inc   = r_beat + 2'd1;
    assign w_split_byte = r_wdata[{w_beat_inc, 3'b000} +: 8];

    // On the last split beat the formatter sees the fully assembled word.
    assign w_fmt_size   = (r_state == SPLIT) ? SIZE_WORD : r_size;
    assign w_fmt_raw    = (r_state == SPLIT) ? {mem.mem_rdata[7:0], r_asm} : mem.mem_rdata;

    lsu_load_fmt u_load_fmt (
        .i_size     (w_fmt_size),
        .i_unsigned (r_unsigned),
        .i_raw      (w_fmt_raw),
        .o_data     (w_fmt_data)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_beat_nxt       = r_beat;
        w_asm_nxt        = r_asm;
        w_resp_valid_nxt = 1'b0;
        w_resp_err_nxt   = 1'b0;
        w_resp_rdata_nxt = 32'b0;
        w_mem_addr_nxt   = '0;
        w_mem_wdata_nxt  = 32'b0;
        w_mem_size_nxt   = SIZE_BYTE;
        w_mem_rd_nxt     = 1'b0;
        w_mem_wr_nxt     = 1'b0;

        case (r_state)
            IDLE: begin
                if (req.req_valid) begin
                    if (w_range_err) begin
                        w_state_nxt      = RESP;
                        w_resp_valid_nxt = 1'b1;
                        w_resp_err_nxt   = 1'b1;
                    end else if (w_misaligned) begin
                        w_state_nxt     = SPLIT;
                        w_beat_nxt      = 2'd0;
                        w_mem_addr_nxt  = req.req_addr;
                        w_mem_size_nxt  = SIZE_BYTE;
                        w_mem_wdata_nxt = {24'b0, req.req_wdata[7:0]};
                        w_mem_rd_nxt    = !req.req_we;
                        w_mem_wr_nxt    = req.req_we;
                    end else begin
                        w_state_nxt     = ACCESS;
                        w_mem_addr_nxt  = req.req_addr;
                        w_mem_size_nxt  = req.req_size;
                        w_mem_wdata_nxt = (req.req_size == SIZE_WORD) ? req.req_wdata
                                                                      : {24'b0, req.req_wdata[7:0]};
                        w_mem_rd_nxt    = !req.req_we;
                        w_mem_wr_nxt    = req.req_we;
                    end
                end
            end

            ACCESS: begin
                w_state_nxt      = RESP;
                w_resp_valid_nxt = 1'b1;
                w_resp_rdata_nxt = r_we ? 32'b0 : w_fmt_data;
            end

            SPLIT: begin
                if (!r_we) begin
                    case (r_beat)
                        2'd0:    w_asm_nxt[7:0]   = mem.mem_rdata[7:0];
                        2'd1:    w_asm_nxt[15:8]  = mem.mem_rdata[7:0];
                        2'd2:    w_asm_nxt[23:16] = mem.mem_rdata[7:0];
                        default: w_asm_nxt        = r_asm;
                    endcase
                end
                if (r_beat == 2'd3) begin
                    w_state_nxt      = RESP;
                    w_resp_valid_nxt = 1'b1;
                    w_resp_rdata_nxt = r_we ? 32'b0 : w_fmt_data;
                end else begin
                    w_beat_nxt      = w_beat_inc;
                    w_mem_addr_nxt  = r_addr + ADDR_W'(w_beat_inc);
                    w_mem_size_nxt  = SIZE_BYTE;
                    w_mem_wdata_nxt = {24'b0, w_split_byte};
                    w_mem_rd_nxt    = !r_we;
                    w_mem_wr_nxt    = r_we;
                end
            end

            RESP: begin
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_we         <= 1'b0;
            r_size       <= SIZE_BYTE;
            r_unsigned   <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= 32'b0;
            r_beat       <= 2'd0;
            r_asm        <= 24'b0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= 32'b0;
            r_mem_size   <= SIZE_BYTE;
            r_mem_rd     <= 1'b0;
            r_mem_wr     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_beat       <= w_beat_nxt;
            r_asm        <= w_asm_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_err   <= w_resp_err_nxt;
            r_resp_rdata <= w_resp_rdata_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_mem_size   <= w_mem_size_nxt;
            r_mem_rd     <= w_mem_rd_nxt;
            r_mem_wr     <= w_mem_wr_nxt;
            if (w_accept) begin
                r_we       <= req.req_we;
                r_size     <= req.req_size;
                r_unsigned <= req.req_unsigned;
                r_addr     <= req.req_addr;
                r_wdata    <= req.req_wdata;
            end
        end
    end

    assign req.req_ready  = (r_state == IDLE);
    assign req.resp_valid = r_resp_valid;
    assign req.resp_err   = r_resp_err;
    assign req.resp_rdata = r_resp_rdata;

    assign mem.mem_addr   = r_mem_addr;
    assign mem.mem_wdata  = r_mem_wdata;
    assign mem.mem_size   = r_mem_size;
    assign mem.mem_rd     = r_mem_rd;
    assign mem.mem_wr     = r_mem_wr;

endmodule
`default_nettype wire
